// File: rtl/system_memory_pkg.sv
// Shared types and sizing helpers for the system memory block.
package system_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LOAD,
        ST_OUT
    } sysmem_state_e;

    function automatic int beat_count(input int data_size, input int lanes);
        return data_size / lanes;
    endfunction

    // Beat counters need at least one bit even when a single beat covers the grid.
    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sysmem_beat_counter.sv
// Beat counter with clear, increment, wrap at BEATS-1 and a last-beat flag.
module sysmem_beat_counter
    import system_memory_pkg::*;
#(
    parameter int BEATS = 64,
    parameter int CNT_W = beat_cnt_w(BEATS)
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic incr,
    output logic last
);

    logic [CNT_W-1:0] count;

    assign last = (count == CNT_W'(BEATS - 1));

    // Clear takes precedence so a mode change never inherits a stale position.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/system_memory_v4.sv
// Grid state memory with serial load/readout. Define SYSTEM_MEMORY_RECIRC_EN for non-destructive (rotating) readout.
module system_memory_v4
    import system_memory_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int LANES     = 1,
    parameter int GEN_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [DATA_SIZE-1:0] GRID_IN,
    input  logic [LANES-1:0]     SERIAL_IN,
    input  logic                 RUN_MODE,
    input  logic                 LOAD_MODE,
    input  logic                 OUTPUT_MODE,
    output logic [DATA_SIZE-1:0] SYSTEM_MEM_OUT,
    output logic [LANES-1:0]     SERIAL_OUT,
    output logic                 SERIAL_OUT_VALID,
    output logic                 LOAD_DONE,
    output logic                 OUTPUT_DONE,
    output logic [GEN_W-1:0]     GENERATION
);

    localparam int BEATS = beat_count(DATA_SIZE, LANES);

    sysmem_state_e state, next_state;
    logic do_run, do_load, do_out;
    logic load_clear, out_clear, load_last, out_last;
    logic [DATA_SIZE-1:0] in_reg, out_reg, load_shift, out_shift, out_fill;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Only the highest-priority requested mode acts; with none requested everything holds.
    always_comb begin
        next_state = state;
        do_run     = 1'b0;
        do_load    = 1'b0;
        do_out     = 1'b0;
        if (RUN_MODE) begin
            next_state = ST_RUN;
            do_run     = 1'b1;
        end else if (LOAD_MODE) begin
            next_state = ST_LOAD;
            do_load    = 1'b1;
        end else if (OUTPUT_MODE) begin
            next_state = ST_OUT;
            do_out     = 1'b1;
        end
        load_clear = do_run | (do_out && state != ST_OUT);
        out_clear  = do_run | (do_load && state != ST_LOAD);
    end

    sysmem_beat_counter #(.BEATS(BEATS)) u_load_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (load_clear),
        .incr  (do_load),
        .last  (load_last)
    );

    sysmem_beat_counter #(.BEATS(BEATS)) u_out_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (out_clear),
        .incr  (do_out),
        .last  (out_last)
    );

`ifdef SYSTEM_MEMORY_RECIRC_EN
    assign out_fill = DATA_SIZE'(out_reg[DATA_SIZE-1 -: LANES]);
`else
    assign out_fill = '0;
`endif

    // A load re-syncs the readout copy to the freshly shifted input register.
    assign load_shift = (in_reg << LANES) | DATA_SIZE'(SERIAL_IN);
    assign out_shift  = (out_reg << LANES) | out_fill;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            in_reg           <= '0;
            out_reg          <= '0;
            SERIAL_OUT       <= '0;
            SERIAL_OUT_VALID <= 1'b0;
            LOAD_DONE        <= 1'b0;
            OUTPUT_DONE      <= 1'b0;
            GENERATION       <= '0;
        end else begin
            SERIAL_OUT_VALID <= 1'b0;
            LOAD_DONE        <= 1'b0;
            OUTPUT_DONE      <= 1'b0;
            if (do_run) begin
                in_reg     <= GRID_IN;
                out_reg    <= GRID_IN;
                GENERATION <= GENERATION + GEN_W'(1);
            end else if (do_load) begin
                in_reg    <= load_shift;
                out_reg   <= load_shift;
                LOAD_DONE <= load_last;
                if (u_load_cnt.count == '0) begin
                    GENERATION <= '0;
                end
            end else if (do_out) begin
                SERIAL_OUT       <= out_reg[DATA_SIZE-1 -: LANES];
                SERIAL_OUT_VALID <= 1'b1;
                OUTPUT_DONE      <= out_last;
                out_reg          <= out_shift;
            end
        end
    end

    assign SYSTEM_MEM_OUT = in_reg;

endmodule

// File: tb/tb_system_memory_v4.sv
// Directed bench for system_memory_v4: a 16-bit/4-lane instance plus a 64-bit/1-lane echo instance.
module tb_system_memory_v4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    logic        run_mode = 0, load_mode = 0, output_mode = 0;
    logic [3:0]  serial_in = '0;
    logic [15:0] grid_in = '0;
    logic [15:0] mem_out;
    logic [3:0]  serial_out;
    logic        serial_out_valid, load_done, output_done;
    logic [15:0] generation;

    logic        w_run = 0, w_load = 0, w_out = 0;
    logic [0:0]  w_serial_in = '0;
    logic [63:0] w_grid = '0;
    logic [63:0] w_mem_out;
    logic [0:0]  w_serial_out;
    logic        w_valid, w_load_done, w_output_done;
    logic [15:0] w_generation;

    int total = 0;
    int bad = 0;
    int ld_pulses = 0, ld64_pulses = 0, od64_pulses = 0;

    always #5 CLK = ~CLK;

    system_memory_v4 #(.DATA_SIZE(16), .LANES(4), .GEN_W(16)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .GRID_IN          (grid_in),
        .SERIAL_IN        (serial_in),
        .RUN_MODE         (run_mode),
        .LOAD_MODE        (load_mode),
        .OUTPUT_MODE      (output_mode),
        .SYSTEM_MEM_OUT   (mem_out),
        .SERIAL_OUT       (serial_out),
        .SERIAL_OUT_VALID (serial_out_valid),
        .LOAD_DONE        (load_done),
        .OUTPUT_DONE      (output_done),
        .GENERATION       (generation)
    );

    system_memory_v4 #(.DATA_SIZE(64), .LANES(1), .GEN_W(16)) dut64 (
        .CLK              (CLK),
        .RESET            (RESET),
        .GRID_IN          (w_grid),
        .SERIAL_IN        (w_serial_in),
        .RUN_MODE         (w_run),
        .LOAD_MODE        (w_load),
        .OUTPUT_MODE      (w_out),
        .SYSTEM_MEM_OUT   (w_mem_out),
        .SERIAL_OUT       (w_serial_out),
        .SERIAL_OUT_VALID (w_valid),
        .LOAD_DONE        (w_load_done),
        .OUTPUT_DONE      (w_output_done),
        .GENERATION       (w_generation)
    );

    // Strobes are held for a whole cycle, so one sample per falling edge counts each pulse once.
    always @(negedge CLK) begin
        if (load_done)     ld_pulses++;
        if (w_load_done)   ld64_pulses++;
        if (w_output_done) od64_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic run, input logic load, input logic outp,
                                 input logic [3:0] ser, input logic [15:0] grid);
        run_mode    = run;
        load_mode   = load;
        output_mode = outp;
        serial_in   = ser;
        grid_in     = grid;
        tick();
    endtask

    logic [63:0] pattern;
    logic [63:0] captured;
    logic [3:0]  beats4 [4];
    logic [3:0]  fifth_beat;
    int base;

    initial begin
        pattern  = 64'hDEAD_BEEF_0123_4567;
        captured = '0;
`ifdef SYSTEM_MEMORY_RECIRC_EN
        fifth_beat = 4'hA;
`else
        fifth_beat = 4'h0;
`endif

        RESET = 1'b1;
        #12;
        checkOutput("reset_mem", 64'(mem_out), 64'h0);
        checkOutput("reset_gen", 64'(generation), 64'h0);
        checkOutput("reset_strobes", 64'({serial_out_valid, load_done, output_done, serial_out}), 64'h0);
        RESET = 1'b0;
        tick();

        base = ld_pulses;
        beats4 = '{4'hA, 4'hB, 4'hC, 4'hD};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, beats4[i], 16'h0);
            checkOutput($sformatf("load_done_beat%0d", i), 64'(load_done), 64'(i == 3));
        end
        checkOutput("load_mem_abcd", 64'(mem_out), 64'hABCD);
        applyStimulus(0, 0, 0, 4'h0, 16'h0);
        checkOutput("load_done_once", 64'(ld_pulses - base), 64'd1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 4'h0, 16'h0);
            checkOutput($sformatf("out_beat%0d", i), 64'({serial_out_valid, output_done, serial_out}),
                        64'({1'b1, 1'(i == 3), beats4[i]}));
        end
        applyStimulus(0, 0, 1, 4'h0, 16'h0);
        checkOutput("out_beat5", 64'({serial_out_valid, output_done, serial_out}), 64'({1'b1, 1'b0, fifth_beat}));
        checkOutput("out_keeps_mem", 64'(mem_out), 64'hABCD);
        applyStimulus(0, 0, 0, 4'h0, 16'h0);
        checkOutput("idle_hold", 64'({serial_out_valid, output_done, serial_out}), 64'({2'b00, fifth_beat}));

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 0, 4'h0, 16'h1234);
            checkOutput($sformatf("run_gen%0d", i), 64'(generation), 64'(i));
        end
        checkOutput("run_mem", 64'(mem_out), 64'h1234);
        applyStimulus(0, 1, 0, 4'h5, 16'h0);
        checkOutput("load_clears_gen", 64'(generation), 64'h0);
        checkOutput("load_after_run_mem", 64'(mem_out), 64'h2345);

        applyStimulus(1, 1, 0, 4'hF, 16'h0F0F);
        checkOutput("run_over_load_mem", 64'(mem_out), 64'h0F0F);
        checkOutput("run_over_load_gen", 64'(generation), 64'h1);
        checkOutput("run_over_load_done", 64'(load_done), 64'h0);
        applyStimulus(0, 0, 0, 4'h0, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 0, 4'(i), 16'h0);
            checkOutput($sformatf("cnt0_load_done%0d", i), 64'(load_done), 64'(i == 4));
        end
        checkOutput("cnt0_mem", 64'(mem_out), 64'h1234);

        applyStimulus(0, 1, 1, 4'h5, 16'h0);
        checkOutput("load_over_out", 64'({serial_out_valid, output_done, mem_out}), 64'h2345);

        applyStimulus(0, 1, 0, 4'h6, 16'h0);
        applyStimulus(0, 1, 0, 4'h7, 16'h0);
        RESET = 1'b1;
        #1;
        checkOutput("reset_async_all", 64'({serial_out_valid, load_done, output_done, serial_out, mem_out, generation}), 64'h0);
        applyStimulus(0, 1, 0, 4'h8, 16'h0);
        checkOutput("reset_held_all", 64'({serial_out_valid, load_done, output_done, serial_out, mem_out, generation}), 64'h0);
        RESET = 1'b0;
        base = ld_pulses;
        beats4 = '{4'h8, 4'h9, 4'hA, 4'hB};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, beats4[i], 16'h0);
            checkOutput($sformatf("abort_load_done%0d", i), 64'(load_done), 64'(i == 3));
        end
        applyStimulus(0, 0, 0, 4'h0, 16'h0);
        checkOutput("abort_one_done", 64'(ld_pulses - base), 64'd1);
        checkOutput("abort_mem", 64'(mem_out), 64'h89AB);

        w_load = 1'b1;
        for (int i = 63; i >= 0; i--) begin
            w_serial_in = pattern[i];
            tick();
        end
        w_load = 1'b0;
        tick();
        checkOutput("wide_mem", w_mem_out, pattern);
        w_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            captured = {captured[62:0], w_serial_out};
            if (i == 63) checkOutput("wide_last_done", 64'({w_valid, w_output_done}), 64'h3);
        end
        w_out = 1'b0;
        tick();
        checkOutput("wide_echo", captured, pattern);
        checkOutput("wide_load_done_cnt", 64'(ld64_pulses), 64'd1);
        checkOutput("wide_out_done_cnt", 64'(od64_pulses), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/system_memory_v4.md
SYSTEM_MEMORY_V4 -- requirements
Module: system_memory_v4

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, grid cell count (state bits).
REQ-002 SHALL have parameter LANES, default 1, serial lanes per beat; DATA_SIZE divisible by LANES.
REQ-003 SHALL have parameter GEN_W, default 16, generation counter width.
REQ-004 CLK  input  1  system clock.
REQ-005 RESET  input  1  reset, asynchronous, active-high.
REQ-006 GRID_IN  input  DATA_SIZE  next state from grid calculator.
REQ-007 SERIAL_IN  input  LANES  serial load data; bit LANES-1 is the most significant bit of the beat.
REQ-008 RUN_MODE / LOAD_MODE / OUTPUT_MODE  input  1 each  mode requests; priority RUN > LOAD > OUTPUT.
REQ-009 SYSTEM_MEM_OUT  output  DATA_SIZE  current state (input register contents).
REQ-010 SERIAL_OUT  output  LANES  serial readout beat.
REQ-011 SERIAL_OUT_VALID  output  1  SERIAL_OUT holds a fresh beat this cycle.
REQ-012 LOAD_DONE / OUTPUT_DONE  output  1 each  single-cycle completion pulses.
REQ-013 GENERATION  output  GEN_W  RUN cycles since the last load start.

Function
REQ-014 SHALL define BEATS = DATA_SIZE/LANES and keep a load beat counter and an output beat counter, each clog2(BEATS) wide (minimum 1 bit).
REQ-015 SHALL implement FSM IDLE/RUN/LOAD/OUT: each cycle the state becomes the highest-priority asserted mode, else it holds; with no mode asserted, all registers hold.
REQ-016 RUN cycle: input and output registers <= GRID_IN; both beat counters cleared; GENERATION +1, wrapping modulo 2^GEN_W.
REQ-017 LOAD cycle: input and output registers <= {reg[DATA_SIZE-1-LANES:0], SERIAL_IN}; load counter +1.
REQ-018 A LOAD cycle with load counter 0 SHALL also clear GENERATION.
REQ-019 On the load beat where the counter equals BEATS-1, LOAD_DONE SHALL be 1 in the next cycle and the counter SHALL wrap to 0; extra beats keep shifting and the oldest bits drop out.
REQ-020 Entering LOAD from another state SHALL clear the output counter. Entering OUT from another state SHALL clear the load counter.
REQ-021 OUT cycle: SERIAL_OUT <= output register [DATA_SIZE-1 -: LANES]; SERIAL_OUT_VALID <= 1; output register shifts left by LANES with fill per REQ-028; output counter +1.
REQ-022 The beat emitted with output counter BEATS-1 SHALL assert OUTPUT_DONE in the same cycle as its SERIAL_OUT_VALID; the counter then wraps to 0.
REQ-023 SERIAL_OUT_VALID, LOAD_DONE and OUTPUT_DONE SHALL be 0 in any cycle not produced by REQ-019/021/022; SERIAL_OUT holds its last value.
REQ-024 The input register SHALL be unaffected by OUT cycles; SYSTEM_MEM_OUT SHALL be the input register, with no combinational path from inputs.
REQ-025 Simultaneous mode assertions: only the highest-priority action SHALL occur.

Reset
REQ-026 RESET SHALL asynchronously clear both registers, both counters, GENERATION, SERIAL_OUT, all strobes, and set state IDLE.
REQ-027 RESET asserted mid-load or mid-output SHALL abort the operation; no DONE pulse SHALL follow.

Configuration
REQ-028 With SYSTEM_MEMORY_RECIRC_EN defined, the output shift SHALL fill with the bits shifted out (rotate), making readout non-destructive; without it, the fill SHALL be zeros.

Structure
REQ-029 A shared package system_memory_pkg SHALL hold the FSM state enum and a beat-count helper function.
REQ-030 A sub-module sysmem_beat_counter (clear, increment, wrap at BEATS-1, last-beat flag) SHALL be instantiated twice.

Verification (DATA_SIZE=16, LANES=4 unless noted)
REQ-031 LOAD beats 0xA,0xB,0xC,0xD -> SYSTEM_MEM_OUT=0xABCD; LOAD_DONE pulses once, one cycle after the 4th beat.
REQ-032 After REQ-031, OUTPUT_MODE for 4 cycles -> SERIAL_OUT A,B,C,D with VALID each cycle; OUTPUT_DONE on the D beat; 5th beat = 0 (or A with SYSTEM_MEMORY_RECIRC_EN).
REQ-033 RUN_MODE with GRID_IN=0x1234 for 3 cycles -> SYSTEM_MEM_OUT=0x1234, GENERATION=3; the next load beat -> GENERATION=0.
REQ-034 RUN_MODE and LOAD_MODE together with SERIAL_IN=0xF, GRID_IN=0x0F0F -> register=0x0F0F, load counter 0, no LOAD_DONE.
REQ-035 RESET after 2 load beats, then 4 beats -> exactly one LOAD_DONE; all outputs 0 during RESET.
REQ-036 DATA_SIZE=64, LANES=1: 64 load beats then 64 output beats -> bit-exact serial echo; one LOAD_DONE, one OUTPUT_DONE.
